// File: rtl/eth_rx_deframer.sv
// eth_rx_deframer: GMII receive deframer stripping preamble/SFD/FCS and reporting per-frame status
module eth_rx_deframer #(
  parameter logic [47:0] MAC_ADDR = 48'h020000000001,
  parameter bit PROMISC = 1'b0,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        in_rxc,
  input  logic        in_rst,
  input  logic        in_rxdv,
  input  logic [7:0]  in_rxd,
  input  logic        in_rxer,
  output logic        out_rx_valid,
  output logic [7:0]  out_rx_data,
  output logic        out_rx_sof,
  output logic        out_rx_done,
  output logic [2:0]  out_rx_status,
  output logic [10:0] out_rx_len
);
  localparam logic [2:0] IDLE = 3'd0, PRE = 3'd1, DATA = 3'd2, ABORT = 3'd3, DROP = 3'd4;
  localparam logic [11:0] MIN_L = 12'(MIN_LEN);
  localparam logic [11:0] MAX_L = 12'(MAX_LEN);
  localparam logic [7:0][7:0] MAC8 = {MAC_ADDR, 16'h0000};
  logic [2:0] state, pre_cnt, ab_status;
  logic [31:0] crc, crc_nx;
  logic [10:0] cnt, cnt_nx, len_nx;
  logic [3:0][7:0] dl;
  logic uc_ok, bc_ok, hit_uc, hit_bc, addr_fail;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  always_comb begin
    crc_nx = crc_byte(crc, in_rxd);
    cnt_nx = &cnt ? cnt : cnt + 11'd1;
    len_nx = cnt < 11'd4 ? 11'd0 : cnt - 11'd4;
    hit_uc = uc_ok && in_rxd == MAC8[3'd7 - cnt[2:0]];
    hit_bc = bc_ok && in_rxd == 8'hFF;
    addr_fail = cnt == 11'd5 && !(PROMISC || hit_uc || hit_bc);
  end
  always_ff @(posedge in_rxc) begin
    if (in_rst) begin
      state <= IDLE;
      pre_cnt <= 3'd0;
      ab_status <= 3'd0;
      crc <= 32'hFFFFFFFF;
      cnt <= 11'd0;
      dl <= '0;
      uc_ok <= 1'b0;
      bc_ok <= 1'b0;
      out_rx_valid <= 1'b0;
      out_rx_data <= 8'd0;
      out_rx_sof <= 1'b0;
      out_rx_done <= 1'b0;
      out_rx_status <= 3'd0;
      out_rx_len <= 11'd0;
    end else begin
      out_rx_valid <= 1'b0;
      out_rx_sof <= 1'b0;
      out_rx_done <= 1'b0;
      case (state)
        IDLE: if (in_rxdv) begin
          state <= in_rxd == 8'h55 ? PRE : DROP;
          pre_cnt <= 3'd1;
        end
        PRE: if (!in_rxdv) state <= IDLE;
        else if (in_rxd == 8'hD5) begin
          state <= DATA;
          crc <= 32'hFFFFFFFF;
          cnt <= 11'd0;
          uc_ok <= 1'b1;
          bc_ok <= 1'b1;
        end else if (in_rxd == 8'h55 && pre_cnt != 3'd7) pre_cnt <= pre_cnt + 3'd1;
        else state <= DROP;
        DATA: if (!in_rxdv) begin
          state <= IDLE;
          out_rx_done <= 1'b1;
          out_rx_len <= len_nx;
          out_rx_status <= {1'b0, cnt} < MIN_L ? 3'd2 : crc != 32'hDEBB20E3 ? 3'd1 : 3'd0;
        end else begin
          crc <= crc_nx;
          cnt <= cnt_nx;
          dl <= {dl[2:0], in_rxd};
          uc_ok <= hit_uc;
          bc_ok <= hit_bc;
          out_rx_valid <= cnt >= 11'd4;
          out_rx_sof <= cnt == 11'd4;
          out_rx_data <= cnt >= 11'd4 ? dl[3] : out_rx_data;
          if (in_rxer || addr_fail || {1'b0, cnt_nx} > MAX_L) begin
            state <= ABORT;
            ab_status <= in_rxer ? 3'd4 : addr_fail ? 3'd5 : 3'd3;
          end
        end
        ABORT: if (!in_rxdv) begin
          state <= IDLE;
          out_rx_done <= 1'b1;
          out_rx_len <= len_nx;
          out_rx_status <= ab_status;
        end else cnt <= cnt_nx;
        DROP: if (!in_rxdv) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_rx_deframer.sv
// tb_eth_rx_deframer: randomized scoreboard bench for eth_rx_deframer (PROMISC off and on)
module tb_eth_rx_deframer;
  localparam logic [47:0] MAC = 48'h020000000001;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  logic clk, rst, rxdv, rxer;
  logic [7:0] rxd;
  logic v0, s0, dn0, v1, s1, dn1;
  logic [7:0] d0, d1;
  logic [2:0] st0, st1;
  logic [10:0] ln0, ln1;
  logic [8:0] qb0[$], qb1[$];
  logic [13:0] qd0[$], qd1[$];
  logic [7:0] fr[$];
  int checks = 0;
  int errs = 0;
  eth_rx_deframer #(.MAC_ADDR(MAC), .PROMISC(1'b0), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .in_rxc(clk), .in_rst(rst), .in_rxdv(rxdv), .in_rxd(rxd), .in_rxer(rxer),
    .out_rx_valid(v0), .out_rx_data(d0), .out_rx_sof(s0), .out_rx_done(dn0),
    .out_rx_status(st0), .out_rx_len(ln0)
  );
  eth_rx_deframer #(.MAC_ADDR(MAC), .PROMISC(1'b1), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut_p (
    .in_rxc(clk), .in_rst(rst), .in_rxdv(rxdv), .in_rxd(rxd), .in_rxer(rxer),
    .out_rx_valid(v1), .out_rx_data(d1), .out_rx_sof(s1), .out_rx_done(dn1),
    .out_rx_status(st1), .out_rx_len(ln1)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] pop_b(input int p);
    if (p == 0) begin
      if (qb0.size() == 0) return 32'hFFFFFFFF;
      return {23'b0, qb0.pop_front()};
    end
    if (qb1.size() == 0) return 32'hFFFFFFFF;
    return {23'b0, qb1.pop_front()};
  endfunction
  function automatic logic [31:0] pop_d(input int p);
    if (p == 0) begin
      if (qd0.size() == 0) return 32'hFFFFFFFF;
      return {18'b0, qd0.pop_front()};
    end
    if (qd1.size() == 0) return 32'hFFFFFFFF;
    return {18'b0, qd1.pop_front()};
  endfunction
  always @(negedge clk) begin
    if (v0) chk("beat", {23'b0, s0, d0}, pop_b(0));
    if (v1) chk("beat_promisc", {23'b0, s1, d1}, pop_b(1));
    if (dn0) chk("done", {18'b0, st0, ln0}, pop_d(0));
    if (dn1) chk("done_promisc", {18'b0, st1, ln1}, pop_d(1));
  end
  function automatic logic [31:0] crc32(input logic [7:0] f[$], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, f[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return ~c;
  endfunction
  task automatic mk(input logic [47:0] dst, input int n, input bit bad);
    logic [31:0] c;
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(i < 6 ? dst[47 - 8 * i -: 8] : 8'($urandom));
    c = crc32(fr, n);
    if (bad) c = c ^ (32'd1 << $urandom_range(0, 31));
    for (int i = 0; i < 4; i++) fr.push_back(c[8 * i +: 8]);
  endtask
  task automatic model(input int er, input int rs);
    int n, ab, st, last, l;
    logic [47:0] dst;
    n = fr.size();
    for (int p = 0; p < 2; p++) begin
      ab = n;
      st = 0;
      if (er >= 0 && er < n) begin
        ab = er;
        st = 4;
      end
      if (n >= 6) begin
        dst = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
        if (!(p == 1 || dst == MAC || dst == 48'hFFFFFFFFFFFF) && 5 < ab) begin
          ab = 5;
          st = 5;
        end
      end
      if (n > MAX_LEN && MAX_LEN < ab) begin
        ab = MAX_LEN;
        st = 3;
      end
      last = (rs >= 0 && rs <= ab) ? rs - 1 : (ab < n ? ab : n - 1);
      for (int k = 0; k + 4 <= last; k++) begin
        if (p == 0) qb0.push_back({k == 0, fr[k]});
        else qb1.push_back({k == 0, fr[k]});
      end
      if (rs < 0) begin
        if (ab == n) st = n < MIN_LEN ? 2 : crc32(fr, n - 4) == {fr[n-1], fr[n-2], fr[n-3], fr[n-4]} ? 0 : 1;
        l = (n > 2047 ? 2047 : n) - 4;
        if (l < 0) l = 0;
        if (p == 0) qd0.push_back({3'(st), 11'(l)});
        else qd1.push_back({3'(st), 11'(l)});
      end
    end
  endtask
  task automatic cyc(input logic dv, input logic [7:0] d, input logic er);
    rxdv = dv;
    rxd = d;
    rxer = er;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int er, input int rs);
    model(er, rs);
    for (int i = 0; i < 8; i++) cyc(1'b1, i == 7 ? 8'hD5 : 8'h55, 1'b0);
    for (int i = 0; i < fr.size(); i++) begin
      rst = i == rs;
      cyc(1'b1, fr[i], i == er);
      if (i == rs) begin
        rst = 1'b0;
        chk("rst_valid", {31'b0, v0}, 32'd0);
        chk("rst_status", {29'b0, st0}, 32'd0);
        chk("rst_len", {21'b0, ln0}, 32'd0);
      end
    end
    cyc(1'b0, 8'h00, 1'b0);
  endtask
  task automatic send_raw(input int n55, input logic [7:0] tail0);
    for (int i = 0; i < n55; i++) cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, tail0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 8'($urandom), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [47:0] dst;
    int n, er;
    rst = 1'b1;
    rxdv = 1'b0;
    rxd = 8'h00;
    rxer = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {31'b0, v0}, 32'd0);
    chk("reset_done", {31'b0, dn0}, 32'd0);
    chk("reset_status_len", {18'b0, st0, ln0}, 32'd0);
    rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    mk(MAC, 60, 1'b0); send(-1, -1);
    mk(MAC, 60, 1'b1); send(-1, -1);
    mk(48'h020000000002, 60, 1'b0); send(-1, -1);
    mk(MAC, 40, 1'b0); send(-1, -1);
    mk(MAC, 1600, 1'b0); send(-1, -1);
    mk(MAC, 60, 1'b0); send(20, -1);
    mk(MAC, 60, 1'b0); send(-1, -1);
    send_raw(2, 8'hAA);
    send_raw(8, 8'hD5);
    mk(48'hFFFFFFFFFFFF, 56, 1'b0); send(9, -1);
    mk(MAC, 60, 1'b0);
    if (fr[31] == 8'h55) fr[31] = 8'h00;
    send(-1, 30);
    mk(MAC, 60, 1'b0); send(-1, -1);
    mk(MAC, 0, 1'b0); send(-1, -1);
    mk(48'hFFFFFFFFFFFF, 64, 1'b0); send(-1, -1);
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 2))
        0: dst = MAC;
        1: dst = 48'hFFFFFFFFFFFF;
        default: dst = {16'(MAC[47:32]), 32'($urandom)};
      endcase
      n = $urandom_range(0, 110);
      mk(dst, n, $urandom_range(0, 3) == 0);
      er = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, n + 3)) : -1;
      send(er, -1);
    end
    repeat (5) cyc(1'b0, 8'h00, 1'b0);
    chk("beats_left", qb0.size(), 32'd0);
    chk("beats_left_promisc", qb1.size(), 32'd0);
    chk("dones_left", qd0.size(), 32'd0);
    chk("dones_left_promisc", qd1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
